// File: rtl/toggle_sync_pkg.sv
// toggle_sync_pkg: shared edge-mode type, parameter limits and edge-qualify helper
package toggle_sync_pkg;
    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;
    localparam int N_CH_MIN = 1;
    localparam int N_CH_MAX = 32;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;
    localparam int FILTER_MIN = 0;
    localparam int FILTER_MAX = 15;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 16;
    localparam int FLT_W = 4;
    localparam int INIT_W = 5;
    function automatic logic edge_hit(edge_mode_e mode, logic cur, logic prev);
        return mode == EDGE_RISE ? cur & ~prev :
               mode == EDGE_FALL ? ~cur & prev : cur ^ prev;
    endfunction
endpackage

// File: rtl/toggle_sync_ch.sv
// toggle_sync_ch: one channel of synchronizer, glitch filter, edge pulse, sticky flag and event counter
module toggle_sync_ch
    import toggle_sync_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 0,
    parameter edge_mode_e EDGE_MODE   = EDGE_RISE,
    parameter int         CNT_W       = 8
) (
    input  logic             clk_b,
    input  logic             rst_b_n,
    input  logic             sig_in,
    input  logic             evt_clr,
    input  logic             en,
    output logic             sig_sync,
    output logic             pulse_sync,
    output logic             evt_flag,
    output logic [CNT_W-1:0] evt_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync;
    logic sync_out;
    logic sig_prev;
    assign sync_out = sync[SYNC_STAGES-1];
    always_ff @(posedge clk_b or negedge rst_b_n)
        if (!rst_b_n) sync <= '0;
        else sync <= {sync[SYNC_STAGES-2:0], sig_in};
    if (FILTER_LEN == 0) begin : g_bypass
        assign sig_sync = sync_out;
    end else begin : g_filter
        logic [FLT_W-1:0] flt_cnt;
        // accept the new level only after it has differed for FILTER_LEN consecutive cycles
        always_ff @(posedge clk_b or negedge rst_b_n)
            if (!rst_b_n) begin
                flt_cnt  <= '0;
                sig_sync <= 1'b0;
            end else if (sync_out == sig_sync) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                flt_cnt  <= '0;
                sig_sync <= sync_out;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
    end
    always_ff @(posedge clk_b or negedge rst_b_n)
        if (!rst_b_n) begin
            sig_prev   <= 1'b0;
            pulse_sync <= 1'b0;
            evt_flag   <= 1'b0;
            evt_cnt    <= '0;
        end else begin
            sig_prev   <= sig_sync;
            pulse_sync <= en & edge_hit(EDGE_MODE, sig_sync, sig_prev);
            evt_flag   <= pulse_sync | (evt_flag & ~evt_clr);
            evt_cnt    <= evt_clr ? CNT_W'(pulse_sync) :
                          (pulse_sync && evt_cnt != CNT_MAX) ? evt_cnt + 1'b1 : evt_cnt;
        end
endmodule

// File: rtl/toggle_sync_mc.sv
// toggle_sync_mc: N_CH independent level synchronizers with post-reset pulse suppression
module toggle_sync_mc
    import toggle_sync_pkg::*;
#(
    parameter int         N_CH        = 4,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 0,
    parameter edge_mode_e EDGE_MODE   = EDGE_RISE,
    parameter int         CNT_W       = 8
) (
    input  logic                  clk_b,
    input  logic                  rst_b_n,
    input  logic [N_CH-1:0]       sig_in,
    input  logic [N_CH-1:0]       evt_clr,
    output logic [N_CH-1:0]       sig_sync,
    output logic [N_CH-1:0]       pulse_sync,
    output logic [N_CH-1:0]       evt_flag,
    output logic [N_CH*CNT_W-1:0] evt_cnt,
    output logic                  init_done
);
    localparam int INIT_LAST = SYNC_STAGES + FILTER_LEN;
    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
        $error("toggle_sync_mc: N_CH out of range");
    end
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("toggle_sync_mc: SYNC_STAGES out of range");
    end
    if (FILTER_LEN < FILTER_MIN || FILTER_LEN > FILTER_MAX) begin : g_bad_filter
        $error("toggle_sync_mc: FILTER_LEN out of range");
    end
    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("toggle_sync_mc: CNT_W out of range");
    end
    if (EDGE_MODE > EDGE_BOTH) begin : g_bad_edge
        $error("toggle_sync_mc: EDGE_MODE illegal");
    end
    logic [INIT_W-1:0] init_cnt;
    // pulses stay masked until the pipeline has flushed the levels present at reset release
    always_ff @(posedge clk_b or negedge rst_b_n)
        if (!rst_b_n) begin
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else if (!init_done) begin
            init_cnt  <= init_cnt + 1'b1;
            init_done <= init_cnt == INIT_W'(INIT_LAST);
        end
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        toggle_sync_ch #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN),
            .EDGE_MODE  (EDGE_MODE),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk_b     (clk_b),
            .rst_b_n   (rst_b_n),
            .sig_in    (sig_in[i]),
            .evt_clr   (evt_clr[i]),
            .en        (init_done),
            .sig_sync  (sig_sync[i]),
            .pulse_sync(pulse_sync[i]),
            .evt_flag  (evt_flag[i]),
            .evt_cnt   (evt_cnt[i*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_toggle_sync_mc.sv
// tb_toggle_sync_mc: directed checks on a default instance and a filtered both-edge instance
module tb_toggle_sync_mc;
    import toggle_sync_pkg::*;
    logic        clk_b = 1'b0;
    logic        rst_b_n;
    logic [3:0]  sig_in_a, evt_clr_a, sig_sync_a, pulse_a, flag_a;
    logic [31:0] cnt_a;
    logic        init_a;
    logic [3:0]  sig_in_b, evt_clr_b, sig_sync_b, pulse_b, flag_b;
    logic [15:0] cnt_b;
    logic        init_b;
    int tests = 0;
    int fails = 0;
    int npulse2 = 0;
    int base;
    int model [4];
    logic [3:0] prev, nv;

    always #5 clk_b = ~clk_b;

    toggle_sync_mc dut_a (
        .clk_b(clk_b), .rst_b_n(rst_b_n), .sig_in(sig_in_a), .evt_clr(evt_clr_a),
        .sig_sync(sig_sync_a), .pulse_sync(pulse_a), .evt_flag(flag_a),
        .evt_cnt(cnt_a), .init_done(init_a)
    );

    toggle_sync_mc #(.FILTER_LEN(3), .EDGE_MODE(EDGE_BOTH), .CNT_W(4)) dut_b (
        .clk_b(clk_b), .rst_b_n(rst_b_n), .sig_in(sig_in_b), .evt_clr(evt_clr_b),
        .sig_sync(sig_sync_b), .pulse_sync(pulse_b), .evt_flag(flag_b),
        .evt_cnt(cnt_b), .init_done(init_b)
    );

    always @(negedge clk_b) if (pulse_b[2]) npulse2++;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_b);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lvl"}, {6'd0, sig_sync_a, pulse_a, flag_a, init_a, sig_sync_b, pulse_b, flag_b, init_b}, 32'd0);
        chk({tag, "_cnt_a"}, cnt_a, 32'd0);
        chk({tag, "_cnt_b"}, {16'd0, cnt_b}, 32'd0);
    endtask

    initial begin
        rst_b_n = 1'b0;
        sig_in_a = 4'h0;
        sig_in_b = 4'hF;
        evt_clr_a = 4'h0;
        evt_clr_b = 4'h0;
        cyc(3);
        chk_all_zero("reset");
        rst_b_n = 1'b1;
        cyc(2);
        chk("init_a_low", init_a, 0);
        cyc(1);
        chk("init_a_high", init_a, 1);
        cyc(1);
        chk("hold_sync_b_early", sig_sync_b, 4'h0);
        cyc(1);
        chk("hold_sync_b", sig_sync_b, 4'hF);
        chk("init_b_low", init_b, 0);
        cyc(1);
        chk("init_b_high", init_b, 1);
        chk("hold_pulse_b", pulse_b, 4'h0);
        cyc(2);
        chk("hold_pulse_b_late", pulse_b, 4'h0);
        chk("hold_cnt_b", cnt_b, 16'h0);
        chk("hold_flag_b", flag_b, 4'h0);
        chk("idle_sync_a", sig_sync_a, 4'h0);

        sig_in_a = 4'b0001;
        cyc(1);
        chk("a_sync_lat1", sig_sync_a, 4'h0);
        cyc(1);
        chk("a_sync_lat2", sig_sync_a, 4'b0001);
        chk("a_pulse_early", pulse_a, 4'h0);
        cyc(1);
        chk("a_pulse", pulse_a, 4'b0001);
        chk("a_cnt_before", cnt_a, 32'h0);
        cyc(1);
        chk("a_pulse_end", pulse_a, 4'h0);
        chk("a_cnt", cnt_a, 32'h1);
        chk("a_flag", flag_a, 4'b0001);

        sig_in_b = 4'h0;
        cyc(8);
        chk("b_fall_sync", sig_sync_b, 4'h0);
        chk("b_fall_cnt", cnt_b, 16'h1111);
        chk("b_fall_flag", flag_b, 4'hF);
        evt_clr_b = 4'hF;
        evt_clr_a = 4'b0010;
        cyc(1);
        evt_clr_b = 4'h0;
        evt_clr_a = 4'h0;
        chk("b_clr_cnt", cnt_b, 16'h0);
        chk("b_clr_flag", flag_b, 4'h0);
        chk("a_clr_noop_cnt", cnt_a, 32'h1);
        chk("a_clr_noop_flag", flag_a, 4'b0001);

        sig_in_b[1] = 1'b1;
        cyc(2);
        sig_in_b[1] = 1'b0;
        cyc(8);
        chk("b_glitch_sync", sig_sync_b, 4'h0);
        chk("b_glitch_cnt", cnt_b, 16'h0);
        chk("b_glitch_flag", flag_b, 4'h0);
        sig_in_b[1] = 1'b1;
        cyc(4);
        chk("b_filt_early", sig_sync_b, 4'h0);
        sig_in_b[1] = 1'b0;
        cyc(1);
        chk("b_filt_rise", sig_sync_b, 4'b0010);
        cyc(1);
        chk("b_filt_pulse", pulse_b, 4'b0010);
        cyc(6);
        chk("b_filt_fall", sig_sync_b, 4'h0);
        chk("b_filt_cnt", cnt_b, 16'h0020);
        chk("b_filt_flag", flag_b, 4'b0010);

        sig_in_b[0] = 1'b1;
        cyc(3);
        rst_b_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        cyc(2);
        rst_b_n = 1'b1;
        cyc(8);
        chk("post_rst_sync_a", sig_sync_a, 4'b0001);
        chk("post_rst_sync_b", sig_sync_b, 4'b0001);
        chk("post_rst_cnt_a", cnt_a, 32'h0);
        chk("post_rst_cnt_b", cnt_b, 16'h0);
        chk("post_rst_flags", {flag_a, flag_b}, 8'h0);
        chk("post_rst_init", {init_a, init_b}, 2'b11);

        base = npulse2;
        for (int i = 0; i < 20; i++) begin
            sig_in_b[2] = ~sig_in_b[2];
            cyc(5);
        end
        cyc(4);
        chk("b_tog_pulses", npulse2 - base, 20);
        chk("b_tog_sat", cnt_b[11:8], 4'hF);
        chk("b_tog_flag", flag_b, 4'b0100);
        chk("b_tog_indep", {cnt_b[15:12], cnt_b[7:0]}, 12'h0);
        sig_in_b[2] = 1'b1;
        cyc(6);
        chk("b_clr_pulse", pulse_b[2], 1'b1);
        evt_clr_b = 4'b0100;
        cyc(1);
        evt_clr_b = 4'h0;
        chk("b_clr_set_cnt", cnt_b[11:8], 4'h1);
        chk("b_clr_set_flag", flag_b[2], 1'b1);

        evt_clr_a = 4'hF;
        cyc(1);
        evt_clr_a = 4'h0;
        for (int k = 0; k < 4; k++) model[k] = 0;
        prev = sig_in_a;
        for (int i = 0; i < 200; i++) begin
            nv = 4'($urandom);
            for (int k = 0; k < 4; k++) if (nv[k] && !prev[k]) model[k]++;
            sig_in_a = nv;
            prev = nv;
            cyc(1);
        end
        cyc(6);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rand_cnt%0d", k), 32'(cnt_a[k*8 +: 8]), model[k]);
            chk($sformatf("rand_flag%0d", k), 32'(flag_a[k]), 32'(model[k] != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/toggle_sync_mc.md
TOGGLE_SYNC_MC -- requirements
Module: toggle_sync_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent channels, 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth, 2..4.
REQ-003 SHALL have parameter FILTER_LEN, default 0: stability cycles required before a level change is accepted, 0..15; 0 means bypass.
REQ-004 SHALL have parameter EDGE_MODE, default EDGE_RISE (edge_mode_e): edge that generates a pulse; one of EDGE_RISE, EDGE_FALL or EDGE_BOTH.
REQ-005 SHALL have parameter CNT_W, default 8: per-channel event counter width, 1..16.
REQ-006 SHALL have port clk_b, input, 1 bit: destination clock; the only clock in the block.
REQ-007 SHALL have port rst_b_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port sig_in, input, N_CH bits: asynchronous level inputs, one bit per channel.
REQ-009 SHALL have port evt_clr, input, N_CH bits: synchronous per-channel clear for the sticky flag and the counter.
REQ-010 SHALL have port sig_sync, output, N_CH bits: synchronized and filtered level.
REQ-011 SHALL have port pulse_sync, output, N_CH bits: one-cycle pulse on the selected edge.
REQ-012 SHALL have port evt_flag, output, N_CH bits: sticky event flag.
REQ-013 SHALL have port evt_cnt, output, N_CH*CNT_W bits: channel k's counter occupies bits [k*CNT_W +: CNT_W].
REQ-014 SHALL have port init_done, output, 1 bit: high once post-reset pulse suppression has ended.

Function
REQ-015 SHALL pass each sig_in bit through SYNC_STAGES flops; stage 1 and stage 2 carry ASYNC_REG="TRUE".
REQ-016 SHALL, with FILTER_LEN=0, drive sig_sync from the last synchronizer stage: latency SYNC_STAGES cycles after the first clk_b edge that samples the new input.
REQ-017 SHALL, with FILTER_LEN>0, keep a per-channel counter:
- increments while the synchronized value differs from sig_sync;
- resets to 0 whenever they are equal;
- sig_sync takes the new value on the cycle the count reaches FILTER_LEN; the counter then returns to 0.
REQ-018 SHALL give a total level latency of SYNC_STAGES+FILTER_LEN cycles; input glitches shorter than FILTER_LEN destination cycles SHALL NOT change sig_sync.
REQ-019 SHALL register pulse_sync one cycle after sig_sync changes, comparing sig_sync with a registered copy of itself:
- EDGE_RISE: 0->1 only;
- EDGE_FALL: 1->0 only;
- EDGE_BOTH: any change.
REQ-020 SHALL keep pulse_sync exactly one cycle wide per accepted edge; back-to-back accepted edges SHALL give pulses on consecutive qualifying cycles with no merging.
REQ-021 SHALL set evt_flag[k] on pulse_sync[k] and clear it on evt_clr[k]; simultaneous set and clear leaves evt_flag[k]=1.
REQ-022 SHALL increment evt_cnt[k] on pulse_sync[k] and saturate at 2^CNT_W-1 without wrapping.
REQ-023 SHALL load evt_cnt[k] with 0 on evt_clr[k]; simultaneous evt_clr[k] and pulse_sync[k] loads 1.
REQ-024 SHALL treat evt_clr with no pending events as a no-op; channels SHALL be fully independent.
REQ-025 SHALL run a shared init counter from reset release for SYNC_STAGES+FILTER_LEN+1 cycles:
- init_done=0 while it runs; pulse_sync, evt_flag and evt_cnt updates are suppressed;
- sig_sync tracks normally during this window;
- init_done=1 from the following cycle until the next reset.

Reset
REQ-026 SHALL, while rst_b_n=0, asynchronously clear all synchronizer stages, filter counters, the sig_sync registers and their copies, pulse_sync, evt_flag, evt_cnt, the init counter and init_done to 0.
REQ-027 SHALL deassert reset synchronously to clk_b; reset release is externally synchronized.
REQ-028 SHALL, on reset asserted mid-filter or mid-pulse, discard the pending change with no pulse; behaviour after release is per REQ-025.

Structure
REQ-029 SHALL place edge_mode_e (EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2) and the parameter range limits in toggle_sync_pkg.
REQ-030 SHALL implement one sub-module, toggle_sync_ch (synchronizer, filter, edge detect, flag, counter), instantiated N_CH times by generate; the init counter stays in the top level.
REQ-031 SHALL reject illegal parameter values by elaboration-time assertion.

Verification
REQ-032 Default parameters, FILTER_LEN=0; sig_in[0] 0->1 three cycles after init_done -> sig_sync[0]=1 two cycles later, pulse_sync[0] one cycle after that, evt_cnt[0]=1, evt_flag[0]=1.
REQ-033 FILTER_LEN=3; sig_in[1] high-pulse lasting 2 cycles -> no sig_sync or pulse change; pulse lasting 4 cycles -> sig_sync[1] rises 5 cycles after the edge.
REQ-034 EDGE_BOTH, CNT_W=4; 20 toggles on ch2 -> 20 pulses, evt_cnt[2] stuck at 15; evt_clr[2] in the same cycle as a pulse -> evt_cnt[2]=1, evt_flag[2]=1.
REQ-035 sig_in=4'hF held through reset -> sig_sync=4'hF after SYNC_STAGES+FILTER_LEN cycles, no pulses, evt_cnt all 0, init_done rising after the REQ-025 count.
REQ-036 rst_b_n pulsed low while a FILTER_LEN=3 change is pending -> all outputs 0 immediately, no pulse after release.
REQ-037 Random independent toggling on all 4 channels against a reference model -> per-channel pulse counts and flags match, with no cross-channel interaction.
